// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared constants, state enum and helpers for the 7-segment scan decoder
// Purpose: glyph patterns (active-high gfedcba), anode indices, bus widths, FSM state type.
package seg_scan_pkg;

   localparam int VALUE_W    = 14;
   localparam int SEG_W      = 12;
   localparam int NUM_DIGITS = 4;

   localparam logic [6:0] GLYPH_0     = 7'h3F;
   localparam logic [6:0] GLYPH_1     = 7'h06;
   localparam logic [6:0] GLYPH_2     = 7'h5B;
   localparam logic [6:0] GLYPH_3     = 7'h4F;
   localparam logic [6:0] GLYPH_4     = 7'h66;
   localparam logic [6:0] GLYPH_5     = 7'h6D;
   localparam logic [6:0] GLYPH_6     = 7'h7D;
   localparam logic [6:0] GLYPH_7     = 7'h07;
   localparam logic [6:0] GLYPH_8     = 7'h7F;
   localparam logic [6:0] GLYPH_9     = 7'h6F;
   localparam logic [6:0] GLYPH_BLANK = 7'h00;

   localparam int AN0_IDX = 0;
   localparam int AN1_IDX = 1;
   localparam int AN2_IDX = 2;
   localparam int AN3_IDX = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

   // True when exactly one active-low anode is driven.
   function automatic logic onehot_low(input logic [3:0] an);
      logic [3:0] act;
      act = ~an;
      return (act != 4'b0000) && ((act & (act - 4'd1)) == 4'b0000);
   endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// rtl/seg_glyph_decode.sv - combinational 7-segment glyph to BCD digit decoder
// Purpose: classify one active-high gfedcba pattern.
// Ports: glyph_i   in  7  active-high segments g..a
//        illegal_o out 1  pattern is neither a digit nor blank
//        blank_o   out 1  all segments off (digit reads as 0)
//        digit_o   out 4  decoded digit, 0 when blank or illegal
module seg_glyph_decode
   import seg_scan_pkg::*;
(
   input  logic [6:0] glyph_i,
   output logic       illegal_o,
   output logic       blank_o,
   output logic [3:0] digit_o
);

   always_comb begin
      illegal_o = 1'b0;
      blank_o   = 1'b0;
      digit_o   = 4'd0;
      case (glyph_i)
         GLYPH_0:     digit_o = 4'd0;
         GLYPH_1:     digit_o = 4'd1;
         GLYPH_2:     digit_o = 4'd2;
         GLYPH_3:     digit_o = 4'd3;
         GLYPH_4:     digit_o = 4'd4;
         GLYPH_5:     digit_o = 4'd5;
         GLYPH_6:     digit_o = 4'd6;
         GLYPH_7:     digit_o = 4'd7;
         GLYPH_8:     digit_o = 4'd8;
         GLYPH_9:     digit_o = 4'd9;
         GLYPH_BLANK: blank_o = 1'b1;
         default:     illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - receive-side monitor of a multiplexed 4-digit 7-segment bus
// Purpose: rebuild the displayed decimal value, DP and blank pattern from the scanned bus.
// Ports: clk_i    in  1   rising-edge clock
//        rst_ni   in  1   asynchronous active-low reset
//        seg_i    in  12  [11:8] anodes AN3..AN0 low-active, [7] DP low-active, [6:0] g..a low-active
//        value_o  out 14  last good decoded value
//        dots_o   out 4   DP per digit of last good frame, low-active, [3]=thousands
//        blank_o  out 4   blank flag per digit of last good frame
//        valid_o  out 1   pulse when value/dots/blank update
//        err_o    out 1   pulse on illegal glyph frame or frame timeout
module seg_scan_decoder
   import seg_scan_pkg::*;
#(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [SEG_W-1:0]   seg_i,
   output logic [VALUE_W-1:0] value_o,
   output logic [3:0]         dots_o,
   output logic [3:0]         blank_o,
   output logic               valid_o,
   output logic               err_o
);

   localparam logic [7:0]  STAB_MAX = 8'(STABLE_CYCLES - 1);
   localparam logic [23:0] TMO_MAX  = 24'(TIMEOUT_CYCLES - 1);

   logic [SEG_W-1:0]   sync1_q, sync2_q, prev_q;
   logic [7:0]         stab_q, stab_d;
   logic [23:0]        tmo_q, tmo_d;
   logic [3:0][7:0]    slot_q, slot_d;   // {dp (low-active), glyph (active-high)}
   logic [3:0][7:0]    conv_q, conv_d;
   logic [3:0]         seen_q, seen_d;
   state_e             state_q, state_d;
   logic [1:0]         idx_q, idx_d;
   logic [VALUE_W-1:0] acc_q, acc_d;
   logic [VALUE_W-1:0] value_q, value_d;
   logic [3:0]         dots_q, dots_d, blank_q, blank_d;
   logic               valid_q, valid_d, err_q, err_d;

   logic [3:0]         dec_illegal, dec_blank;
   logic [3:0][3:0]    dec_digit;
   logic [1:0]         an_idx;
   logic               accept, frame_start, timeout_hit;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
      seg_glyph_decode u_dec (
         .glyph_i   (conv_q[i][6:0]),
         .illegal_o (dec_illegal[i]),
         .blank_o   (dec_blank[i]),
         .digit_o   (dec_digit[i])
      );
   end

   // Digit capture and frame/timeout bookkeeping.
   always_comb begin
      stab_d = stab_q;
      slot_d = slot_q;
      seen_d = seen_q;
      tmo_d  = tmo_q;
      accept = 1'b0;
      an_idx = 2'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!sync2_q[8+i]) an_idx = 2'(i);
      end

      if (!onehot_low(sync2_q[11:8]) || (sync2_q != prev_q)) begin
         stab_d = 8'd0;
      end else if (stab_q != STAB_MAX) begin
         stab_d = stab_q + 8'd1;
         accept = (stab_q == STAB_MAX - 8'd1);
      end

      frame_start = (state_q == IDLE) && (seen_q == 4'b1111);
      timeout_hit = (seen_q != 4'b0000) && (tmo_q == TMO_MAX) && !frame_start;

      if (frame_start || timeout_hit) seen_d = 4'b0000;
      if (accept) begin
         slot_d[an_idx] = {sync2_q[7], ~sync2_q[6:0]};
         seen_d[an_idx] = 1'b1;
      end

      if ((seen_q == 4'b0000) || frame_start || timeout_hit) tmo_d = 24'd0;
      else                                                  tmo_d = tmo_q + 24'd1;
   end

   // Conversion FSM: thousands digit first, acc*10 built from two shifts.
   always_comb begin
      state_d = state_q;
      conv_d  = conv_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      value_d = value_q;
      dots_d  = dots_q;
      blank_d = blank_q;
      valid_d = 1'b0;
      err_d   = timeout_hit;
      case (state_q)
         IDLE: begin
            if (frame_start) begin
               conv_d  = slot_q;
               acc_d   = '0;
               idx_d   = 2'd0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            // ~idx_q walks slot 3 down to slot 0.
            acc_d = (acc_q << 3) + (acc_q << 1) + {10'd0, dec_digit[~idx_q]};
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
            if (|dec_illegal) begin
               err_d = 1'b1;
            end else begin
               value_d = acc_q;
               dots_d  = {conv_q[3][7], conv_q[2][7], conv_q[1][7], conv_q[0][7]};
               blank_d = dec_blank;
               valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= '1;
         sync2_q <= '1;
         prev_q  <= '1;
         stab_q  <= '0;
         tmo_q   <= '0;
         slot_q  <= '0;
         conv_q  <= '0;
         seen_q  <= '0;
         state_q <= IDLE;
         idx_q   <= '0;
         acc_q   <= '0;
         value_q <= '0;
         dots_q  <= 4'b1111;
         blank_q <= 4'b0000;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         sync1_q <= seg_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         stab_q  <= stab_d;
         tmo_q   <= tmo_d;
         slot_q  <= slot_d;
         conv_q  <= conv_d;
         seen_q  <= seen_d;
         state_q <= state_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         value_q <= value_d;
         dots_q  <= dots_d;
         blank_q <= blank_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign value_o = value_q;
   assign dots_o  = dots_q;
   assign blank_o = blank_q;
   assign valid_o = valid_q;
   assign err_o   = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] seg;
   logic [13:0] value;
   logic [3:0]  dots, blank;
   logic        valid, err;

   int total = 0;
   int bad   = 0;
   int n_valid = 0, n_err = 0, base_v = 0, base_e = 0;

   logic [13:0] exp_value;
   logic [3:0]  exp_dots, exp_blank;
   logic [6:0]  gt [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   always #5 clk = ~clk;

   seg_scan_decoder #(.STABLE_CYCLES(16), .TIMEOUT_CYCLES(200)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .seg_i   (seg),
      .value_o (value),
      .dots_o  (dots),
      .blank_o (blank),
      .valid_o (valid),
      .err_o   (err)
   );

   always @(negedge clk) begin
      if (valid === 1'b1) n_valid++;
      if (err === 1'b1)   n_err++;
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [11:0] word(input int an, input logic dp, input logic [6:0] g);
      logic [3:0] a;
      a = 4'b1111;
      a[an] = 1'b0;
      return {a, dp, ~g};
   endfunction

   function automatic bit is_legal(input logic [6:0] g);
      if (g == 7'h00) return 1'b1;
      for (int k = 0; k < 10; k++) if (gt[k] == g) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drive(input logic [11:0] v, input int n);
      seg = v;
      cyc(n);
   endtask

   // g[3] is the thousands digit, scanned first.
   task automatic scan(input logic [3:0][6:0] g, input logic [3:0] dp, input int hold);
      for (int i = 3; i >= 0; i--) drive(word(i, dp[i], g[i]), hold);
      drive(12'hFFF, 20);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic mark();
      base_v = n_valid;
      base_e = n_err;
   endtask

   task automatic post_check(input string tag, input int dv, input int de);
      chk({tag, ".valid_pulses"}, 32'(n_valid - base_v), 32'(dv));
      chk({tag, ".err_pulses"},   32'(n_err - base_e),   32'(de));
      chk({tag, ".value"}, {18'd0, value}, {18'd0, exp_value});
      chk({tag, ".dots"},  {28'd0, dots},  {28'd0, exp_dots});
      chk({tag, ".blank"}, {28'd0, blank}, {28'd0, exp_blank});
   endtask

   initial begin
      logic [3:0][6:0] g;
      logic [3:0]      dp, bmask;
      int              d [4];
      int              hold, val;
      bit              corrupt;

      seg   = 12'hFFF;
      rst_n = 1'b0;
      cyc(3);
      chk("reset.value", {18'd0, value}, 32'd0);
      chk("reset.dots",  {28'd0, dots},  32'hF);
      chk("reset.blank", {28'd0, blank}, 32'h0);
      chk("reset.valid", {31'd0, valid}, 32'd0);
      chk("reset.err",   {31'd0, err},   32'd0);
      rst_n = 1'b1;
      cyc(5);

      // "2015" with DP on the hundreds digit
      mark();
      scan({gt[2], gt[0], gt[1], gt[5]}, 4'b1011, 20);
      exp_value = 14'd2015; exp_dots = 4'b1011; exp_blank = 4'b0000;
      post_check("f2015", 1, 0);

      // three blank digits then 7
      mark();
      scan({7'h00, 7'h00, 7'h00, gt[7]}, 4'b1111, 20);
      exp_value = 14'd7; exp_dots = 4'b1111; exp_blank = 4'b1110;
      post_check("blank7", 1, 0);

      // "1200" with units glyph corrupted: outputs hold
      mark();
      scan({gt[1], gt[2], gt[0], 7'h3E}, 4'b0000, 20);
      post_check("corrupt", 0, 1);

      // units digit held one cycle too short -> frame never completes, timeout
      mark();
      drive(word(3, 1'b1, gt[3]), 20);
      drive(word(2, 1'b1, gt[4]), 20);
      drive(word(1, 1'b1, gt[5]), 20);
      drive(word(0, 1'b1, gt[6]), 15);
      drive(12'hFFF, 220);
      post_check("short", 0, 1);
      // seen must have been cleared: a lone units digit cannot finish a frame
      mark();
      drive(word(0, 1'b1, gt[5]), 20);
      drive(12'hFFF, 20);
      post_check("seen_clr", 0, 0);
      drive(12'hFFF, 200);
      chk("seen_clr.timeout", 32'(n_err - base_e), 32'd1);

      // two anodes low: nothing accepted, so no timeout either
      mark();
      drive({4'b0011, 1'b1, ~gt[8]}, 100);
      drive(12'hFFF, 250);
      chk("glitch.err", 32'(n_err - base_e), 32'd0);
      scan({gt[0], gt[8], gt[0], gt[6]}, 4'b1111, 20);
      exp_value = 14'd806; exp_dots = 4'b1111; exp_blank = 4'b0000;
      post_check("f0806", 1, 0);

      // reset during conversion of "9999"
      mark();
      drive(word(3, 1'b1, gt[9]), 20);
      drive(word(2, 1'b1, gt[9]), 20);
      drive(word(1, 1'b1, gt[9]), 20);
      seg = word(0, 1'b1, gt[9]);
      cyc(20);
      rst_n = 1'b0;
      seg   = 12'hFFF;
      cyc(3);
      rst_n = 1'b1;
      cyc(30);
      exp_value = 14'd0; exp_dots = 4'b1111; exp_blank = 4'b0000;
      post_check("abort", 0, 0);
      mark();
      scan({gt[9], gt[9], gt[9], gt[9]}, 4'b1111, 20);
      exp_value = 14'd9999;
      post_check("f9999", 1, 0);

      // randomized frames against an arithmetic model
      for (int f = 0; f < 8; f++) begin
         dp    = 4'($urandom_range(15));
         hold  = $urandom_range(16, 30);
         val   = 0;
         bmask = 4'b0000;
         for (int i = 3; i >= 0; i--) begin
            d[i]     = $urandom_range(9);
            bmask[i] = ($urandom_range(3) == 0);
            if (bmask[i]) d[i] = 0;
            g[i]     = bmask[i] ? 7'h00 : gt[d[i]];
         end
         val = d[3] * 1000 + d[2] * 100 + d[1] * 10 + d[0];
         corrupt = ($urandom_range(3) == 0);
         if (corrupt) begin
            logic [6:0] bg;
            int         pos;
            pos = $urandom_range(3);
            do bg = 7'($urandom_range(127)); while (is_legal(bg));
            g[pos] = bg;
         end
         mark();
         scan(g, dp, hold);
         if (corrupt) begin
            post_check($sformatf("rnd%0d", f), 0, 1);
         end else begin
            exp_value = 14'(val); exp_dots = dp; exp_blank = bmask;
            post_check($sformatf("rnd%0d", f), 1, 0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
